mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port unified instruction/data memory between two requesters: Fetch (IF, read-only, 16-bit) and the MEM stage (read/write, 16- or 32-bit).
- 32-bit MEM accesses (PC push/pop, wide loads/stores) run as two 16-bit beats.
- Produces per-requester stall signals consumed by the pipeline hazard logic.
- Sits between the IF/MEM stages and the memory macro.

Parameters:
- ADDR_W, 12, word-address width; the memory holds 2^ADDR_W words of 16 bits.
- DATA_W, 16, memory word width.
- ACC_CYC, 2, cycles one beat occupies the memory port (legal range 1..7).
- STARVE_MAX, 4, consecutive MEM grants before IF is forced. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request, held high until if_valid.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetched word.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_valid.
- mem_req  in  1  data request, held high until mem_valid.
- mem_we  in  1  1 = write.
- mem_wide  in  1  1 = 32-bit (two beats).
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  2*DATA_W  write data; low half is used for narrow accesses.
- mem_rdata  out  2*DATA_W  read data; upper half is zero for narrow reads.
- mem_valid  out  1  one-cycle completion pulse for data.
- mem_stall  out  1  mem_req & ~mem_valid.
- ram_en  out  1  memory enable.
- ram_we  out  1  memory write enable.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_rdata  in  DATA_W  memory read data, valid on the last cycle of a beat.

Behaviour:
- States: IDLE, ACC_LO, ACC_HI, DONE.
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; beat counter and starvation counter go to 0.
  - ram_en, ram_we, if_valid and mem_valid go to 0.
  - if_rdata and mem_rdata go to 0.
  - ram_addr and ram_wdata go to 0.
- Reset mid-operation abandons the access. A wide write may leave only its low beat written; this is accepted.
- IDLE arbitration:
  - If mem_req is high, grant MEM; otherwise if if_req is high, grant IF.
  - The grant, address, we, wide and wdata are registered, and the FSM moves to ACC_LO.
  - Requests are not sampled in any other state.
- ACC_LO and ACC_HI:
  - ram_en=1 for exactly ACC_CYC cycles.
  - ram_we equals the registered we for all ACC_CYC cycles.
  - ram_addr/ram_wdata are held stable for the whole beat.
  - ram_rdata is captured on the final cycle of the beat.
- Beat mapping:
  - LO beat: address addr, wdata[DATA_W-1:0], fills rdata[DATA_W-1:0].
  - HI beat: address (addr+1) mod 2^ADDR_W, wdata[2*DATA_W-1:DATA_W], fills the upper half. Address 2^ADDR_W-1 wraps to 0.
- After the final ACC_LO cycle: go to ACC_HI if the grant is MEM and wide; otherwise go to DONE.
- DONE: lasts one cycle and is the only cycle in which the matching valid is high. ram_en=0. Next state is IDLE unconditionally. The requester drops or changes its request in this cycle.
- Latency from request-high in IDLE to valid: narrow = ACC_CYC+1 cycles; wide = 2*ACC_CYC+1 cycles. With default ACC_CYC=2 these are 3 and 5.
- if_rdata and mem_rdata hold their values until the next completion of the same requester. Writes leave mem_rdata unchanged.
- Simultaneous requests: MEM wins. IF waits in stall with no timeout, unless the optional feature is enabled.
- Request dropped while granted is illegal. The arbiter completes the access regardless.

Optional Feature:
- Macro: MEM_PORT_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - The counter increments on each MEM grant made while if_req is high.
  - It clears on any IF grant.
  - When it equals STARVE_MAX, the next IDLE arbitration with if_req high grants IF even if mem_req is high.
- Without the macro: strict MEM priority; the counter and STARVE_MAX are absent from the logic.

Decomposition:
- Package mem_port_arb_pkg:
  - FSM state enum.
  - Grant enum (GNT_IF, GNT_MEM).
  - Default constants for DATA_W and ACC_CYC.
- One natural sub-module, mem_port_arb_beat_timer:
  - A loadable down-counter of ACC_CYC width.
  - Outputs: busy, and last (final beat cycle).
  - Reused for both beats.

Test Plan:
- Reset mid-beat (rst_n=0 during ACC_LO) → next cycle state IDLE, ram_en=0, no valid, outputs 0.
- IF-only read: if_req=1, if_addr=0x010, memory word 0xA5A5 → ram_en high for 2 cycles at 0x010; if_valid pulses on cycle 3; if_rdata=0xA5A5.
- Wide MEM write: mem_addr=0xFFF, wdata=0x1234_5678, ACC_CYC=2 → 0x5678 written at 0xFFF, then 0x1234 at 0x000 (wrap); mem_valid on cycle 5.
- Simultaneous if_req and mem_req (narrow read 0x200) → MEM served first. IF is granted in the IDLE following DONE, so its valid arrives 4 cycles after mem_valid. if_stall stays high throughout.
- Back-to-back: mem_req drops in DONE, if_req held → IF granted in the next IDLE. No double-grant of MEM.
- Guard enabled, STARVE_MAX=4, mem_req and if_req held continuously → 4 MEM completions, then 1 IF completion; the pattern repeats. With the macro undefined, IF never completes.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the FSM state encoding, the grant encoding and the latched access control word.
package mem_port_arb_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int ACC_CYC_DEF = 2;
  // ACC_CYC is limited to 1..7, so three bits always hold the beat count.
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;

  typedef struct packed {
    gnt_t gnt;
    logic we;
    logic wide;
  } acc_ctl_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around the arbiter.
// master = pipeline stages plus memory macro; slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_wide;
  logic [ADDR_W-1:0]     mem_addr;
  logic [2*DATA_W-1:0]   mem_wdata;
  logic [2*DATA_W-1:0]   mem_rdata;
  logic                  mem_valid;
  logic                  mem_stall;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_wide, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_wide, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arb_beat_timer.sv
// Purpose: loadable down-counter timing one memory beat of ACC_CYC cycles.
// Latency: busy the cycle after load, last on the final cycle of the beat.
// Backpressure: none; a load always restarts the count.
module mem_port_arb_beat_timer
  import mem_port_arb_pkg::*;
#(
  parameter int ACC_CYC = ACC_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(ACC_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one 16-bit memory port between fetch and MEM; optional fetch guard MEM_PORT_ARB_STARVE_GUARD_EN.
// Latency: narrow ACC_CYC+1 cycles, wide 2*ACC_CYC+1 cycles from request seen in IDLE to valid.
// Backpressure: requesters hold req and see stall until their one-cycle valid; MEM wins ties.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_CYC    = ACC_CYC_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  state_t              state, state_nxt;
  acc_ctl_t            ctl;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [2*DATA_W-1:0] mem_rdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   lo_buf;
  logic                timer_load;
  logic                beat_busy;
  logic                beat_last;
  logic                grant_if;
  logic                any_req;
  logic                in_beat;
  logic                if_vld;
  logic                mem_vld;

  assign any_req = bus.mem_req | bus.if_req;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] starve_cnt;
  logic            force_if;

  assign force_if = (starve_cnt == SC_W'(STARVE_MAX));
  assign grant_if = bus.if_req & (~bus.mem_req | force_if);

  // Counts MEM grants that left a waiting fetch behind; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && any_req) begin
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (bus.if_req) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign grant_if = bus.if_req & ~bus.mem_req;
`endif

  mem_port_arb_beat_timer #(
    .ACC_CYC (ACC_CYC)
  ) u_beat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .busy  (beat_busy),
    .last  (beat_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt  = ST_ACC_LO;
          timer_load = 1'b1;
        end
      end
      ST_ACC_LO: begin
        if (beat_last) begin
          if (ctl.gnt == GNT_MEM && ctl.wide) begin
            state_nxt  = ST_ACC_HI;
            timer_load = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_ACC_HI: begin
        if (beat_last) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read data is published on entry to DONE so outputs only move at a completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      lo_buf      <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        ctl.gnt  <= grant_if ? GNT_IF : GNT_MEM;
        ctl.we   <= ~grant_if & bus.mem_we;
        ctl.wide <= ~grant_if & bus.mem_wide;
        addr_q   <= grant_if ? bus.if_addr : bus.mem_addr;
        wdata_q  <= grant_if ? '0 : bus.mem_wdata;
      end
      if (state == ST_ACC_LO && beat_last) begin
        if (ctl.gnt == GNT_IF) begin
          if_rdata_q <= bus.ram_rdata;
        end else if (!ctl.we) begin
          if (ctl.wide) begin
            lo_buf <= bus.ram_rdata;
          end else begin
            mem_rdata_q <= {{DATA_W{1'b0}}, bus.ram_rdata};
          end
        end
      end
      if (state == ST_ACC_HI && beat_last && !ctl.we) begin
        mem_rdata_q <= {bus.ram_rdata, lo_buf};
      end
    end
  end

  assign in_beat = (state == ST_ACC_LO) || (state == ST_ACC_HI);
  assign if_vld  = (state == ST_DONE) && (ctl.gnt == GNT_IF);
  assign mem_vld = (state == ST_DONE) && (ctl.gnt == GNT_MEM);

  assign bus.ram_en    = in_beat & beat_busy;
  assign bus.ram_we    = in_beat & beat_busy & ctl.we;
  assign bus.ram_addr  = (state == ST_ACC_HI) ? addr_q + ADDR_W'(1) : addr_q;
  assign bus.ram_wdata = (state == ST_ACC_HI) ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_vld;
  assign bus.if_stall  = bus.if_req & ~if_vld;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_valid = mem_vld;
  assign bus.mem_stall = bus.mem_req & ~mem_vld;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 4K x 16 memory.
// Starvation pattern expectations follow MEM_PORT_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (12),
    .DATA_W     (16),
    .ACC_CYC    (2),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the clock edge; pre_* preloads words.
  logic [15:0] ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [15:0] pre_dat;

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_dat;
    end else if (bus.ram_en && bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  assign bus.ram_rdata = ram[bus.ram_addr];

  int n_cmp = 0;
  int n_err = 0;

  int          en_cycles;
  logic [11:0] first_addr;
  logic [11:0] last_addr;
  logic [15:0] last_wdata;
  int          if_stall_cnt;
  int          mem_vld_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_dat  = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Steps negedges until the watched valid appears; cyc stays 0 if the budget expires.
  task automatic run_req(input bit want_if, input int budget, output int cyc);
    cyc        = 0;
    en_cycles  = 0;
    first_addr = 12'h0;
    last_addr  = 12'h0;
    last_wdata = 16'h0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.ram_en) begin
        if (en_cycles == 0) first_addr = bus.ram_addr;
        last_addr  = bus.ram_addr;
        last_wdata = bus.ram_wdata;
        en_cycles++;
      end
      if (bus.if_stall) if_stall_cnt++;
      if (bus.mem_valid) mem_vld_cnt++;
      if (want_if ? bus.if_valid : bus.mem_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int          cyc;
    int          n_done;
    logic [9:0]  order;
    logic [9:0]  exp_order;

    clk           = 1'b0;
    rst_n         = 1'b0;
    pre_we        = 1'b0;
    pre_addr      = 12'h0;
    pre_dat       = 16'h0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 12'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wide  = 1'b0;
    bus.mem_addr  = 12'h0;
    bus.mem_wdata = 32'h0;
    if_stall_cnt  = 0;
    mem_vld_cnt   = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_ram_en",    32'(bus.ram_en),    32'h0);
    check_eq("rst_ram_we",    32'(bus.ram_we),    32'h0);
    check_eq("rst_if_valid",  32'(bus.if_valid),  32'h0);
    check_eq("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    check_eq("rst_if_rdata",  32'(bus.if_rdata),  32'h0);
    check_eq("rst_mem_rdata", bus.mem_rdata,      32'h0);
    check_eq("rst_ram_addr",  32'(bus.ram_addr),  32'h0);
    check_eq("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);

    poke(12'h010, 16'hA5A5);
    poke(12'h200, 16'hBEEF);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch-only narrow read.
    bus.if_addr  = 12'h010;
    bus.if_req   = 1'b1;
    if_stall_cnt = 0;
    run_req(1'b1, 20, cyc);
    bus.if_req = 1'b0;
    check_eq("if_latency",   32'(cyc),          32'd3);
    check_eq("if_en_cycles", 32'(en_cycles),    32'd2);
    check_eq("if_ram_addr",  32'(first_addr),   32'h010);
    check_eq("if_rdata",     32'(bus.if_rdata), 32'hA5A5);
    check_eq("if_stall_cyc", 32'(if_stall_cnt), 32'd2);
    check_eq("if_mem_rdata", bus.mem_rdata,     32'h0);
    @(negedge clk);

    // Wide write across the top of memory: high beat wraps to address 0.
    bus.mem_addr  = 12'hFFF;
    bus.mem_we    = 1'b1;
    bus.mem_wide  = 1'b1;
    bus.mem_wdata = 32'h1234_5678;
    bus.mem_req   = 1'b1;
    run_req(1'b0, 20, cyc);
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    check_eq("ww_latency",    32'(cyc),        32'd5);
    check_eq("ww_en_cycles",  32'(en_cycles),  32'd4);
    check_eq("ww_lo_addr",    32'(first_addr), 32'hFFF);
    check_eq("ww_hi_addr",    32'(last_addr),  32'h000);
    check_eq("ww_hi_wdata",   32'(last_wdata), 32'h1234);
    @(negedge clk);
    check_eq("ww_ram_fff",    32'(ram[12'hFFF]), 32'h5678);
    check_eq("ww_ram_000",    32'(ram[12'h000]), 32'h1234);
    check_eq("ww_mem_rdata",  bus.mem_rdata,     32'h0);

    // Wide read of the same pair.
    bus.mem_wide = 1'b1;
    bus.mem_req  = 1'b1;
    run_req(1'b0, 20, cyc);
    bus.mem_req  = 1'b0;
    bus.mem_wide = 1'b0;
    check_eq("wr_latency", 32'(cyc),      32'd5);
    check_eq("wr_rdata",   bus.mem_rdata, 32'h1234_5678);
    @(negedge clk);

    // Simultaneous requests: MEM first, fetch in the following IDLE.
    poke(12'h010, 16'h5A5A);
    bus.mem_addr = 12'h200;
    bus.if_addr  = 12'h010;
    bus.mem_req  = 1'b1;
    bus.if_req   = 1'b1;
    if_stall_cnt = 0;
    mem_vld_cnt  = 0;
    run_req(1'b0, 20, cyc);
    bus.mem_req = 1'b0;
    check_eq("sim_mem_latency", 32'(cyc),      32'd3);
    check_eq("sim_mem_rdata",   bus.mem_rdata, 32'h0000_BEEF);
    run_req(1'b1, 20, cyc);
    bus.if_req = 1'b0;
    check_eq("sim_if_after_mem", 32'(cyc),          32'd4);
    check_eq("sim_if_rdata",     32'(bus.if_rdata), 32'h5A5A);
    check_eq("sim_if_stall_cyc", 32'(if_stall_cnt), 32'd6);
    check_eq("sim_mem_grants",   32'(mem_vld_cnt),  32'd1);
    @(negedge clk);

    // Reset in the middle of the low beat.
    bus.mem_addr = 12'h010;
    bus.mem_wide = 1'b1;
    bus.mem_req  = 1'b1;
    @(negedge clk);
    check_eq("mid_ram_en_before", 32'(bus.ram_en), 32'h1);
    rst_n       = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_wide = 1'b0;
    @(negedge clk);
    check_eq("mid_ram_en",    32'(bus.ram_en),    32'h0);
    check_eq("mid_mem_valid", 32'(bus.mem_valid), 32'h0);
    check_eq("mid_if_valid",  32'(bus.if_valid),  32'h0);
    check_eq("mid_mem_rdata", bus.mem_rdata,      32'h0);
    check_eq("mid_if_rdata",  32'(bus.if_rdata),  32'h0);
    check_eq("mid_ram_addr",  32'(bus.ram_addr),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held: record the order of completions (1 = fetch).
    bus.mem_addr = 12'h200;
    bus.if_addr  = 12'h010;
    bus.mem_req  = 1'b1;
    bus.if_req   = 1'b1;
    n_done = 0;
    order  = '0;
    for (int i = 0; i < 100 && n_done < 10; i++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        order[n_done] = 1'b1;
        n_done++;
      end else if (bus.mem_valid) begin
        n_done++;
      end
    end
    bus.mem_req = 1'b0;
    bus.if_req  = 1'b0;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    exp_order = 10'b10_0001_0000;
`else
    exp_order = 10'b00_0000_0000;
`endif
    check_eq("starve_done", 32'(n_done), 32'd10);
    check_eq("starve_order", 32'(order), 32'(exp_order));
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
